axim: RTL and testbench

AXIM -- requirements
Module: axim

---
 rtl/axim.sv | 135 +++++++++++++
 tb/tb_axim.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axim.sv
// LSU-to-AXI4-Lite bridge: turns one LSU request into a single AXI write or read.
// Every AXI-facing output is a register; one transaction is in flight at a time.
module axim (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hs_ls4axim_val,
    input  logic [31:0] i_adr,
    input  logic [31:0] i_wdat,
    input  logic [3:0]  i_wen,
    input  logic        i_ren,
    output logic        hs_axim4ls_rdy,
    output logic [31:0] o_rdat,
    output logic        o_err,
    output logic        o_awvalid,
    input  logic        i_awready,
    output logic [31:0] o_awaddr,
    output logic [2:0]  o_awprot,
    output logic        o_wvalid,
    input  logic        i_wready,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_wstrb,
    input  logic        i_bvalid,
    output logic        o_bready,
    input  logic [1:0]  i_bresp,
    output logic        o_arvalid,
    input  logic        i_arready,
    output logic [31:0] o_araddr,
    output logic [2:0]  o_arprot,
    input  logic        i_rvalid,
    output logic        o_rready,
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_rresp
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        WRESP = 3'd2,
        RADR  = 3'd3,
        RDAT  = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t state;

    assign o_awprot = 3'b000;
    assign o_arprot = 3'b000;

    // Write completes its address/data phase once each channel has handshaken,
    // whether earlier (valid already dropped) or on this edge.
    logic aw_ok;
    logic w_ok;
    assign aw_ok = !o_awvalid || i_awready;
    assign w_ok  = !o_wvalid  || i_wready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            o_awvalid      <= 1'b0;
            o_wvalid       <= 1'b0;
            o_bready       <= 1'b0;
            o_arvalid      <= 1'b0;
            o_rready       <= 1'b0;
            hs_axim4ls_rdy <= 1'b0;
            o_err          <= 1'b0;
            o_rdat         <= 32'h0;
            o_awaddr       <= 32'h0;
            o_wdata        <= 32'h0;
            o_wstrb        <= 4'h0;
            o_araddr       <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs_ls4axim_val) begin
                        if (i_wen != 4'b0000) begin
                            o_awaddr  <= i_adr;
                            o_wdata   <= i_wdat;
                            o_wstrb   <= i_wen;
                            o_awvalid <= 1'b1;
                            o_wvalid  <= 1'b1;
                            state     <= WR;
                        end else if (i_ren) begin
                            o_araddr  <= i_adr;
                            o_arvalid <= 1'b1;
                            state     <= RADR;
                        end else begin
                            hs_axim4ls_rdy <= 1'b1;
                            o_err          <= 1'b0;
                            state          <= DONE;
                        end
                    end
                end
                WR: begin
                    if (o_awvalid && i_awready) o_awvalid <= 1'b0;
                    if (o_wvalid && i_wready)   o_wvalid  <= 1'b0;
                    if (aw_ok && w_ok) begin
                        o_bready <= 1'b1;
                        state    <= WRESP;
                    end
                end
                WRESP: begin
                    if (i_bvalid) begin
                        o_bready       <= 1'b0;
                        o_err          <= (i_bresp != 2'b00);
                        hs_axim4ls_rdy <= 1'b1;
                        state          <= DONE;
                    end
                end
                RADR: begin
                    if (i_arready) begin
                        o_arvalid <= 1'b0;
                        o_rready  <= 1'b1;
                        state     <= RDAT;
                    end
                end
                RDAT: begin
                    if (i_rvalid) begin
                        o_rready       <= 1'b0;
                        o_rdat         <= i_rdata;
                        o_err          <= (i_rresp != 2'b00);
                        hs_axim4ls_rdy <= 1'b1;
                        state          <= DONE;
                    end
                end
                DONE: begin
                    hs_axim4ls_rdy <= 1'b0;
                    o_err          <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axim.sv
// Scoreboard bench for axim: directed LSU requests against a delay-programmable AXI slave.
`timescale 1ns/1ps
module tb_axim;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hs_ls4axim_val;
    logic [31:0] i_adr;
    logic [31:0] i_wdat;
    logic [3:0]  i_wen;
    logic        i_ren;
    logic        hs_axim4ls_rdy;
    logic [31:0] o_rdat;
    logic        o_err;
    logic        o_awvalid;
    logic        i_awready;
    logic [31:0] o_awaddr;
    logic [2:0]  o_awprot;
    logic        o_wvalid;
    logic        i_wready;
    logic [31:0] o_wdata;
    logic [3:0]  o_wstrb;
    logic        i_bvalid;
    logic        o_bready;
    logic [1:0]  i_bresp;
    logic        o_arvalid;
    logic        i_arready;
    logic [31:0] o_araddr;
    logic [2:0]  o_arprot;
    logic        i_rvalid;
    logic        o_rready;
    logic [31:0] i_rdata;
    logic [1:0]  i_rresp;

    always #5 clk = ~clk;

    axim dut (
        .clk(clk), .rst_n(rst_n),
        .hs_ls4axim_val(hs_ls4axim_val), .i_adr(i_adr), .i_wdat(i_wdat),
        .i_wen(i_wen), .i_ren(i_ren), .hs_axim4ls_rdy(hs_axim4ls_rdy),
        .o_rdat(o_rdat), .o_err(o_err),
        .o_awvalid(o_awvalid), .i_awready(i_awready), .o_awaddr(o_awaddr),
        .o_awprot(o_awprot), .o_wvalid(o_wvalid), .i_wready(i_wready),
        .o_wdata(o_wdata), .o_wstrb(o_wstrb), .i_bvalid(i_bvalid),
        .o_bready(o_bready), .i_bresp(i_bresp),
        .o_arvalid(o_arvalid), .i_arready(i_arready), .o_araddr(o_araddr),
        .o_arprot(o_arprot), .i_rvalid(i_rvalid), .o_rready(o_rready),
        .i_rdata(i_rdata), .i_rresp(i_rresp)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // ---------------- slave model ----------------
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    int aw_wait, w_wait, b_wait, ar_wait, r_wait;
    logic aw_got, w_got, b_pend, r_pend;
    logic [31:0] s_rdata = 32'h0;
    logic [1:0]  s_bresp = 2'b00;
    logic [1:0]  s_rresp = 2'b00;
    logic aw_hs, w_hs, ar_hs;

    assign i_awready = o_awvalid && (aw_wait >= aw_dly);
    assign i_wready  = o_wvalid  && (w_wait  >= w_dly);
    assign i_arready = o_arvalid && (ar_wait >= ar_dly);
    assign i_bvalid  = b_pend && (b_wait >= b_dly);
    assign i_rvalid  = r_pend && (r_wait >= r_dly);
    assign i_bresp   = s_bresp;
    assign i_rresp   = s_rresp;
    assign i_rdata   = s_rdata;
    assign aw_hs = o_awvalid && i_awready;
    assign w_hs  = o_wvalid  && i_wready;
    assign ar_hs = o_arvalid && i_arready;

    always @(posedge clk) begin
        if (!rst_n) begin
            aw_wait <= 0; w_wait <= 0; b_wait <= 0; ar_wait <= 0; r_wait <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
        end else begin
            if (o_awvalid && !i_awready) aw_wait <= aw_wait + 1; else if (aw_hs) aw_wait <= 0;
            if (o_wvalid && !i_wready)   w_wait  <= w_wait + 1;  else if (w_hs)  w_wait  <= 0;
            if (o_arvalid && !i_arready) ar_wait <= ar_wait + 1; else if (ar_hs) ar_wait <= 0;
            if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                b_pend <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
            end else begin
                aw_got <= aw_got | aw_hs; w_got <= w_got | w_hs;
            end
            if (b_pend && !i_bvalid) b_wait <= b_wait + 1;
            if (i_bvalid && o_bready) begin b_pend <= 1'b0; b_wait <= 0; end
            if (ar_hs) r_pend <= 1'b1;
            if (r_pend && !i_rvalid) r_wait <= r_wait + 1;
            if (i_rvalid && o_rready) begin r_pend <= 1'b0; r_wait <= 0; end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    logic [31:0] aw_q[$];
    logic [35:0] w_q[$];
    logic [31:0] ar_q[$];
    logic [32:0] rsp_q[$];
    logic [31:0] model_rdat = 32'h0;
    int aw_cyc = 0, w_cyc = 0, ar_cyc = 0, b_cyc = 0, r_cyc = 0, overlap_cyc = 0;

    always @(negedge clk) begin
        if (o_awvalid) begin
            aw_cyc++;
            if (aw_q.size() == 0) fail_now("aw_unexpected");
            else begin
                chk("aw_addr", o_awaddr, aw_q[0]);
                if (i_awready) void'(aw_q.pop_front());
            end
        end
        if (o_wvalid) begin
            w_cyc++;
            if (w_q.size() == 0) fail_now("w_unexpected");
            else begin
                chk("w_data_strb", {o_wdata, o_wstrb}, w_q[0]);
                if (i_wready) void'(w_q.pop_front());
            end
        end
        if (o_arvalid) begin
            ar_cyc++;
            if (ar_q.size() == 0) fail_now("ar_unexpected");
            else begin
                chk("ar_addr", o_araddr, ar_q[0]);
                if (i_arready) void'(ar_q.pop_front());
            end
        end
        if (o_bready) b_cyc++;
        if (o_rready) r_cyc++;
        if (o_bready && (o_awvalid || o_wvalid)) overlap_cyc++;
        if (hs_axim4ls_rdy) begin
            if (rsp_q.size() == 0) fail_now("rdy_unexpected");
            else chk("rsp_rdat_err", {o_rdat, o_err}, rsp_q.pop_front());
        end
    end

    // ---------------- stimulus ----------------
    int s_aw, s_w, s_ar, s_b, s_r, s_ov;

    task automatic start_req(input logic [31:0] adr, input logic [31:0] wdat,
                             input logic [3:0] wen, input logic ren,
                             input logic [31:0] rdata_v, input logic [1:0] resp_v);
        s_aw = aw_cyc; s_w = w_cyc; s_ar = ar_cyc; s_b = b_cyc; s_r = r_cyc; s_ov = overlap_cyc;
        if (wen != 4'b0000) begin
            s_bresp = resp_v;
            aw_q.push_back(adr);
            w_q.push_back({wdat, wen});
            rsp_q.push_back({model_rdat, resp_v != 2'b00});
        end else if (ren) begin
            s_rresp = resp_v;
            s_rdata = rdata_v;
            ar_q.push_back(adr);
            model_rdat = rdata_v;
            rsp_q.push_back({rdata_v, resp_v != 2'b00});
        end else begin
            rsp_q.push_back({model_rdat, 1'b0});
        end
        hs_ls4axim_val = 1'b1; i_adr = adr; i_wdat = wdat; i_wen = wen; i_ren = ren;
        @(posedge clk);
        @(negedge clk);
        // Request fields change right after acceptance; the bridge must ignore them.
        hs_ls4axim_val = 1'b0; i_adr = ~adr; i_wdat = ~wdat; i_wen = 4'hF; i_ren = 1'b1;
    endtask

    task automatic finish_req(input string name, input int exp_cyc);
        int lat;
        lat = 0;
        while (!hs_axim4ls_rdy && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!hs_axim4ls_rdy) fail_now({name, "_timeout"});
        chk({name, "_latency"}, 64'(lat + 1), 64'(exp_cyc));
        @(posedge clk);
        @(negedge clk);
        chk({name, "_rdy_err_after"}, {hs_axim4ls_rdy, o_err}, 2'b00);
    endtask

    task automatic chk_cnt(input string name, input int aw, input int w, input int ar,
                           input int b, input int r);
        chk({name, "_aw_cycles"}, 64'(aw_cyc - s_aw), 64'(aw));
        chk({name, "_w_cycles"},  64'(w_cyc - s_w),   64'(w));
        chk({name, "_ar_cycles"}, 64'(ar_cyc - s_ar), 64'(ar));
        chk({name, "_b_cycles"},  64'(b_cyc - s_b),   64'(b));
        chk({name, "_r_cycles"},  64'(r_cyc - s_r),   64'(r));
        chk({name, "_bready_overlap"}, 64'(overlap_cyc - s_ov), 64'd0);
    endtask

    task automatic pulse_reset(input string name);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({name, "_outputs_zero"},
            {o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready, hs_axim4ls_rdy, o_err, o_rdat},
            64'h0);
        rst_n = 1'b1;
        aw_q.delete(); w_q.delete(); ar_q.delete(); rsp_q.delete();
        model_rdat = 32'h0;
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        hs_ls4axim_val = 1'b0; i_adr = 32'h0; i_wdat = 32'h0; i_wen = 4'h0; i_ren = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs_zero",
            {o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready, hs_axim4ls_rdy, o_err, o_rdat},
            64'h0);
        chk("prot_constant", {o_awprot, o_arprot}, 6'b0);
        rst_n = 1'b1;

        // Plain write accepted in the first cycle out of reset.
        start_req(32'h8001_0004, 32'hDEAD_BEEF, 4'b0011, 1'b0, 32'h0, 2'b00);
        finish_req("wr_basic", 3);
        chk_cnt("wr_basic", 1, 1, 0, 1, 0);

        // Read with AR and R stalls.
        ar_dly = 2; r_dly = 3;
        start_req(32'h4000_0010, 32'h0, 4'b0000, 1'b1, 32'h1234_5678, 2'b00);
        finish_req("rd_stall", 8);
        chk_cnt("rd_stall", 0, 0, 3, 0, 4);
        ar_dly = 0; r_dly = 0;

        // AW completes four cycles before W.
        w_dly = 4;
        start_req(32'h0000_1000, 32'hA5A5_5A5A, 4'b1111, 1'b0, 32'h0, 2'b00);
        finish_req("wr_w_late", 7);
        chk_cnt("wr_w_late", 1, 5, 0, 1, 0);
        w_dly = 0;

        // Error responses; write must not disturb read data.
        start_req(32'h2000_0008, 32'h0, 4'b0000, 1'b1, 32'hCAFE_F00D, 2'b10);
        finish_req("rd_slverr", 3);
        start_req(32'h2000_000C, 32'h0000_0001, 4'b0100, 1'b0, 32'h0, 2'b11);
        finish_req("wr_decerr", 3);
        chk("rdat_kept_after_write", o_rdat, 32'hCAFE_F00D);

        // Write wins over a simultaneous read.
        start_req(32'h3000_0000, 32'h55AA_55AA, 4'b1111, 1'b1, 32'h0, 2'b00);
        finish_req("wr_and_rd", 3);
        chk_cnt("wr_and_rd", 1, 1, 0, 1, 0);

        // Neither read nor write: immediate completion, no AXI traffic.
        start_req(32'h3000_0004, 32'h0, 4'b0000, 1'b0, 32'h0, 2'b00);
        finish_req("no_op", 1);
        chk_cnt("no_op", 0, 0, 0, 0, 0);

        // Reset while stuck in WR.
        w_dly = 10;
        start_req(32'h5000_0000, 32'h1111_2222, 4'b1111, 1'b0, 32'h0, 2'b00);
        @(negedge clk);
        pulse_reset("rst_in_wr");

        // Reset while waiting in RDAT.
        r_dly = 10;
        start_req(32'h6000_0000, 32'h0, 4'b0000, 1'b1, 32'h7777_8888, 2'b00);
        @(negedge clk);
        chk("in_rdat_rready", o_rready, 1'b1);
        pulse_reset("rst_in_rdat");

        // Normal read after the aborted transactions.
        start_req(32'h0000_0100, 32'h0, 4'b0000, 1'b1, 32'h0BAD_F00D, 2'b00);
        finish_req("rd_after_rst", 3);
        chk_cnt("rd_after_rst", 0, 0, 1, 0, 1);

        repeat (2) @(negedge clk);
        chk("queues_drained", 64'(aw_q.size() + w_q.size() + ar_q.size() + rsp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
